// File: rtl/memory_bus_pkg.sv
// Shared definitions for the memory bus responder: bus width defaults,
// wait-state counter width and the responder FSM state encoding.
package memory_bus_pkg;

   localparam int BUS_ADDRESS_SIZE  = 16;
   localparam int BUS_DATA_SIZE     = 8;
   localparam int BUS_MEM_SIZE_LOG2 = 11;

   // Wait-state counter covers the legal 0..15 range.
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_ACCESS  = 3'd2,
      ST_RESPOND = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

endpackage : memory_bus_pkg

// File: rtl/memory_bus_if.sv
// Four-phase memory bus: the initiator raises strobe with a request and
// holds it until ready; the responder holds ready until strobe falls.
interface memory_bus_if
   import memory_bus_pkg::*;
#(
   parameter int ADDRESS_SIZE = BUS_ADDRESS_SIZE,
   parameter int DATA_SIZE    = BUS_DATA_SIZE
);
   logic                    strobe;
   logic                    writeEnable;
   logic [ADDRESS_SIZE-1:0] address;
   logic [DATA_SIZE-1:0]    dataWrite;
   logic [DATA_SIZE-1:0]    dataRead;
   logic                    ready;
   logic                    error;

   // Initiator side.
   modport master (
      output strobe, writeEnable, address, dataWrite,
      input  dataRead, ready, error
   );

   // Memory (responder) side.
   modport slave (
      input  strobe, writeEnable, address, dataWrite,
      output dataRead, ready, error
   );
endinterface : memory_bus_if

// File: rtl/memory_bus_responder_core.sv
// Responder FSM: latches a request, burns the configured wait states,
// performs one storage access and answers with ready/error/dataRead.
module memory_bus_responder_core
   import memory_bus_pkg::*;
#(
   parameter int                    ADDRESS_SIZE  = BUS_ADDRESS_SIZE,
   parameter int                    DATA_SIZE     = BUS_DATA_SIZE,
   parameter int                    MEM_SIZE_LOG2 = BUS_MEM_SIZE_LOG2,
   parameter logic [ADDRESS_SIZE-1:0] BASE_ADDRESS = '0,
   parameter int                    WAIT_STATES   = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    strobe,
   input  logic                    writeEnable,
   input  logic [ADDRESS_SIZE-1:0] address,
   input  logic [DATA_SIZE-1:0]    dataWrite,
   output logic [DATA_SIZE-1:0]    dataRead,
   output logic                    ready,
   output logic                    error
);
   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

   state_t                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
   logic                    we_q, we_d;
   logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
   logic [DATA_SIZE-1:0]    data_read_q, data_read_d;
   logic                    ready_q, ready_d;
   logic                    error_q, error_d;

   logic [ADDRESS_SIZE-1:0] offset;
   logic                    in_range;
   logic                    ram_en;
   logic                    ram_we;
   logic [DATA_SIZE-1:0]    ram_rdata;

   // Offset from the window base; addresses below the base or at/after
   // base + depth are rejected. The top of the address space clips naturally.
   always_comb begin
      offset   = addr_q - BASE_ADDRESS;
      in_range = (addr_q >= BASE_ADDRESS) && ((offset >> MEM_SIZE_LOG2) == '0);
   end

   memory_bus_sram #(
      .DATA_SIZE  (DATA_SIZE),
      .DEPTH_LOG2 (MEM_SIZE_LOG2)
   ) u_sram (
      .clock (clock),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (offset[MEM_SIZE_LOG2-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // Next-state, request latching and response generation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      data_read_d = data_read_q;
      ready_d     = ready_q;
      error_d     = error_q;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (strobe) begin
               addr_d  = address;
               we_d    = writeEnable;
               wdata_d = dataWrite;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - WAIT_CNT_W'(1);
            if (cnt_q <= WAIT_CNT_W'(1)) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            ram_en  = in_range;
            ram_we  = in_range && we_q;
            state_d = ST_RESPOND;
         end
         ST_RESPOND: begin
            ready_d     = 1'b1;
            error_d     = ~in_range;
            data_read_d = (in_range && !we_q) ? ram_rdata : '0;
            state_d     = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!strobe) begin
               ready_d = 1'b0;
               error_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and response registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         data_read_q <= '0;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         data_read_q <= data_read_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
      end
   end

   assign dataRead = data_read_q;
   assign ready    = ready_q;
   assign error    = error_q;
endmodule : memory_bus_responder_core

// File: rtl/memory_bus_sram.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
// Contents are deliberately not reset so the array maps onto block RAM.
module memory_bus_sram #(
   parameter int DATA_SIZE  = 8,
   parameter int DEPTH_LOG2 = 11
) (
   input  logic                  clock,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_SIZE-1:0]  wdata,
   output logic [DATA_SIZE-1:0]  rdata
);
   logic [DATA_SIZE-1:0] mem [0:(2**DEPTH_LOG2)-1];
   logic [DATA_SIZE-1:0] rdata_q;

   // Enabled cycle: optional write, registered read of the addressed word.
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;
endmodule : memory_bus_sram

// File: rtl/memory_bus_responder.sv
// Memory-side attachment of the responder to the memory bus interface.
// Pure port mapping; all behaviour lives in the core.
module memory_bus_responder
   import memory_bus_pkg::*;
#(
   parameter int                    ADDRESS_SIZE  = BUS_ADDRESS_SIZE,
   parameter int                    DATA_SIZE     = BUS_DATA_SIZE,
   parameter int                    MEM_SIZE_LOG2 = BUS_MEM_SIZE_LOG2,
   parameter logic [ADDRESS_SIZE-1:0] BASE_ADDRESS = '0,
   parameter int                    WAIT_STATES   = 1
) (
   input  logic         clock,
   input  logic         reset,
   memory_bus_if.slave  bus
);
   memory_bus_responder_core #(
      .ADDRESS_SIZE  (ADDRESS_SIZE),
      .DATA_SIZE     (DATA_SIZE),
      .MEM_SIZE_LOG2 (MEM_SIZE_LOG2),
      .BASE_ADDRESS  (BASE_ADDRESS),
      .WAIT_STATES   (WAIT_STATES)
   ) u_core (
      .clock       (clock),
      .reset       (reset),
      .strobe      (bus.strobe),
      .writeEnable (bus.writeEnable),
      .address     (bus.address),
      .dataWrite   (bus.dataWrite),
      .dataRead    (bus.dataRead),
      .ready       (bus.ready),
      .error       (bus.error)
   );
endmodule : memory_bus_responder
